// File: rtl/fan_off_timer_ctrl.sv
// Fan off-timer sequencer: preset selection, seconds countdown, expiry pulse, LED/display drive.
// Optional LED blink while held (fan stopped) is enabled with `define TIMER_BLINK_EN.
module fan_off_timer_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int PRESET1_SEC   = 60,
  parameter int PRESET2_SEC   = 180,
  parameter int PRESET3_SEC   = 300,
  parameter int CNT_W         = 14
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             tick_1ms,
  input  logic             btn_mode,
  input  logic             btn_cancel,
  input  logic             fan_on,
  output logic [CNT_W-1:0] remain_sec,
  output logic [1:0]       preset_sel,
  output logic [2:0]       led,
  output logic             timer_active,
  output logic             fan_off_req
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] ONE_SEC   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [1:0]       preset_q, preset_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       led_q, led_d;
  logic             active_q, active_d;
  logic             req_q, req_d;

  function automatic logic [CNT_W-1:0] preset_secs(input logic [1:0] p);
    logic [CNT_W-1:0] s;
    case (p)
      2'd1:    s = CNT_W'(PRESET1_SEC);
      2'd2:    s = CNT_W'(PRESET2_SEC);
      2'd3:    s = CNT_W'(PRESET3_SEC);
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] preset_onehot(input logic [1:0] p);
    logic [2:0] oh;
    case (p)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Sequencer next state: cancel beats mode beats fan stop beats the second event.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    preset_d = preset_q;
    presc_d  = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_mode) begin
          preset_d = 2'd1;
          remain_d = preset_secs(2'd1);
          presc_d  = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (btn_cancel) begin
          preset_d = 2'd0;
          remain_d = '0;
          presc_d  = '0;
          state_d  = ST_IDLE;
        end else if (btn_mode) begin
          // 3 wraps to 0, which ends the timer rather than loading a zero count
          preset_d = preset_q + 2'd1;
          remain_d = preset_secs(preset_d);
          presc_d  = '0;
          state_d  = (preset_d == 2'd0) ? ST_IDLE : ST_RUN;
        end else if (!fan_on) begin
          state_d  = ST_HOLD;
        end else if (state_q == ST_HOLD) begin
          state_d  = ST_RUN;
        end else if (tick_1ms) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (remain_q > ONE_SEC) begin
              remain_d = remain_q - ONE_SEC;
            end else begin
              remain_d = '0;
              preset_d = 2'd0;
              state_d  = ST_DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        preset_d = 2'd0;
        remain_d = '0;
        presc_d  = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        preset_d = 2'd0;
        remain_d = '0;
        presc_d  = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

`ifdef TIMER_BLINK_EN
  localparam int HALF = (TICKS_PER_SEC / 2 > 0) ? TICKS_PER_SEC / 2 : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Blink phase: restarts lit on HOLD entry, toggles every half second of ticks while held.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if ((state_d == ST_HOLD) && tick_1ms) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  // Blink counter registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Output decode from the next state so outputs line up with the state they describe.
  always_comb begin
    if ((state_d == ST_HOLD) && !phase_d) begin
      led_d = 3'b000;
    end else begin
      led_d = preset_onehot(preset_d);
    end
    active_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    req_d    = (state_d == ST_DONE);
  end
`else
  // Output decode from the next state so outputs line up with the state they describe.
  always_comb begin
    led_d    = preset_onehot(preset_d);
    active_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    req_d    = (state_d == ST_DONE);
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      preset_q <= 2'd0;
      presc_q  <= '0;
      led_q    <= 3'b000;
      active_q <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      preset_q <= preset_d;
      presc_q  <= presc_d;
      led_q    <= led_d;
      active_q <= active_d;
      req_q    <= req_d;
    end
  end

  assign remain_sec   = remain_q;
  assign preset_sel   = preset_q;
  assign led          = led_q;
  assign timer_active = active_q;
  assign fan_off_req  = req_q;

endmodule

// File: tb/tb_fan_off_timer_ctrl.sv
// Directed self-checking bench for fan_off_timer_ctrl with a 4-tick second and 3/5/7 s presets.
module tb_fan_off_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset_p, tick_1ms, btn_mode, btn_cancel, fan_on;
  logic [13:0] remain_sec;
  logic [1:0]  preset_sel;
  logic [2:0]  led;
  logic        timer_active, fan_off_req;

  int checks = 0;
  int errors = 0;

  fan_off_timer_ctrl #(
    .TICKS_PER_SEC(4), .PRESET1_SEC(3), .PRESET2_SEC(5), .PRESET3_SEC(7), .CNT_W(14)
  ) dut (
    .clk(clk), .reset_p(reset_p), .tick_1ms(tick_1ms), .btn_mode(btn_mode),
    .btn_cancel(btn_cancel), .fan_on(fan_on), .remain_sec(remain_sec),
    .preset_sel(preset_sel), .led(led), .timer_active(timer_active),
    .fan_off_req(fan_off_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int rem, input int pre, input int ld,
                         input int act, input int req);
    chk({tag, ".remain"}, 32'(remain_sec), rem);
    chk({tag, ".preset"}, 32'(preset_sel), pre);
    chk({tag, ".led"}, 32'(led), ld);
    chk({tag, ".active"}, 32'(timer_active), act);
    chk({tag, ".req"}, 32'(fan_off_req), req);
  endtask

  // One clock: apply inputs, take the edge, sample 1 time unit later, release pulses.
  task automatic cyc(input logic t, input logic m, input logic c);
    tick_1ms = t; btn_mode = m; btn_cancel = c;
    @(posedge clk);
    #1;
    tick_1ms = 1'b0; btn_mode = 1'b0; btn_cancel = 1'b0;
  endtask

  initial begin
    reset_p = 1'b1; tick_1ms = 1'b0; btn_mode = 1'b0; btn_cancel = 1'b0; fan_on = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("por", 0, 0, 0, 0, 0);
    reset_p = 1'b0;

    // Reset taken in the middle of a run at remain_sec=2; reset beats the button.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_rst.remain", 32'(remain_sec), 2);
    reset_p = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    reset_p = 1'b0;
    chk_all("mid_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
    chk_all("idle_ticks", 0, 0, 0, 0, 0);

    // Full countdown from preset 1.
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("p1_load", 3, 1, 1, 1, 0);
    for (int i = 1; i <= 11; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("count.remain", 32'(remain_sec), 32'(3 - i / 4));
      chk("count.req", 32'(fan_off_req), 0);
    end
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("expire", 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("after_done", 0, 0, 0, 0, 0);

    // Mode walks through all presets and back to idle.
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("walk1", 3, 1, 1, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("walk2", 5, 2, 2, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("walk3", 7, 3, 4, 1, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("walk0", 0, 0, 0, 0, 0);

    // Hold with prescaler parked at 2, then resume.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    fan_on = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("hold_enter", 5, 2, 2, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("hold.remain", 32'(remain_sec), 5);
`ifdef TIMER_BLINK_EN
      chk("hold.led", 32'(led), ((i / 2) % 2 == 0) ? 2 : 0);
`else
      chk("hold.led", 32'(led), 2);
`endif
    end
    fan_on = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("resume", 5, 2, 2, 1, 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("resume_t1.remain", 32'(remain_sec), 5);
    cyc(1'b1, 1'b0, 1'b0);
    chk("resume_t2.remain", 32'(remain_sec), 4);

    // Cancel coincident with the final second event.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("to_one.remain", 32'(remain_sec), 1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_cancel.remain", 32'(remain_sec), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk_all("cancel", 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("cancel_next.req", 32'(fan_off_req), 0);

    // Mode coincident with a second-event tick: advance wins and the tick is dropped.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("pre_mt.remain", 32'(remain_sec), 3);
    cyc(1'b1, 1'b1, 1'b0);
    chk_all("mode_tick", 5, 2, 2, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("mt_3ticks.remain", 32'(remain_sec), 5);
    cyc(1'b1, 1'b0, 1'b0);
    chk("mt_4ticks.remain", 32'(remain_sec), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
